// File: rtl/data_sync.sv
// data_sync: 4-phase REQ/ACK handshake that carries a held data bus into the CLK domain.
module data_sync #(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 REQ,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 ENABLE_PULSE,
  output logic                 ACK
);
  typedef enum logic {IDLE, WAIT_LOW} state_t;
  state_t                state_q, state_d;
  logic [NUM_STAGES-1:0] sync_q, sync_d;
  logic                  req_dly_q, req_dly_d;
  logic [BUS_WIDTH-1:0]  bus_q, bus_d;
  logic                  pulse_q, pulse_d;
  logic                  req_s, rise;
  always_comb begin
    sync_d    = {sync_q[NUM_STAGES-2:0], REQ};
    req_s     = sync_q[NUM_STAGES-1];
    req_dly_d = req_s;
    rise      = req_s & ~req_dly_q;
    state_d   = state_q;
    bus_d     = bus_q;
    pulse_d   = 1'b0;
    // The source holds UNSYNC_BUS stable while REQ is high, so it is sampled directly here.
    if (state_q == IDLE && rise) begin
      state_d = WAIT_LOW;
      bus_d   = UNSYNC_BUS;
      pulse_d = 1'b1;
    end else if (state_q == WAIT_LOW && !req_s) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      req_dly_q <= 1'b0;
      bus_q     <= '0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      req_dly_q <= req_dly_d;
      bus_q     <= bus_d;
      pulse_q   <= pulse_d;
    end
  end
  assign SYNC_BUS     = bus_q;
  assign ENABLE_PULSE = pulse_q;
  assign ACK          = (state_q == WAIT_LOW);
endmodule

// File: tb/tb_data_sync.sv
// tb_data_sync: directed vector table plus hand-written multi-cycle sequences for data_sync.
module tb_data_sync;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_a, req_b;
  logic [7:0]  bus_a, sync_a;
  logic [15:0] bus_b, sync_b;
  logic        pulse_a, ack_a, pulse_b, ack_b;
  int          n_chk = 0;
  int          n_pass = 0;
  always #5 clk = ~clk;
  data_sync #(.BUS_WIDTH(8), .NUM_STAGES(2)) dut_a (
    .CLK(clk), .RST_n(rst_n), .UNSYNC_BUS(bus_a), .REQ(req_a),
    .SYNC_BUS(sync_a), .ENABLE_PULSE(pulse_a), .ACK(ack_a)
  );
  data_sync #(.BUS_WIDTH(16), .NUM_STAGES(4)) dut_b (
    .CLK(clk), .RST_n(rst_n), .UNSYNC_BUS(bus_b), .REQ(req_b),
    .SYNC_BUS(sync_b), .ENABLE_PULSE(pulse_b), .ACK(ack_b)
  );
  typedef struct {
    logic       rst_n;
    logic       req;
    logic [7:0] bus;
    logic [7:0] sync;
    logic       pulse;
    logic       ack;
  } vec_t;
  vec_t tbl[23];
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int pulses;
    bit seen;
    rst_n = 1'b0; req_a = 1'b0; bus_a = '0; req_b = 1'b0; bus_b = '0;
    // entry i is driven before edge i and checked just after it
    tbl[0]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 8'hA5, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 8'hA5, 8'h00, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 8'hA5, 8'hA5, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 8'h11, 8'hA5, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 8'h11, 8'hA5, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 8'h11, 8'hA5, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 8'h11, 8'hA5, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 8'h11, 8'hA5, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 8'h11, 8'hA5, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 8'h11, 8'hA5, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 8'h11, 8'hA5, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 8'h3C, 8'hA5, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 8'h3C, 8'hA5, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 8'h3C, 8'h3C, 1'b1, 1'b1};
    tbl[16] = '{1'b1, 1'b0, 8'hC3, 8'h3C, 1'b0, 1'b1};
    tbl[17] = '{1'b1, 1'b0, 8'hC3, 8'h3C, 1'b0, 1'b1};
    tbl[18] = '{1'b1, 1'b0, 8'hC3, 8'h3C, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 1'b1, 8'hC3, 8'h3C, 1'b0, 1'b0};
    tbl[20] = '{1'b1, 1'b1, 8'hC3, 8'h3C, 1'b0, 1'b0};
    tbl[21] = '{1'b1, 1'b1, 8'hC3, 8'hC3, 1'b1, 1'b1};
    tbl[22] = '{1'b1, 1'b1, 8'hC3, 8'hC3, 1'b0, 1'b1};
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      rst_n = tbl[i].rst_n; req_a = tbl[i].req; bus_a = tbl[i].bus;
      tick();
      check($sformatf("v%0d_sync", i), {8'h00, sync_a}, {8'h00, tbl[i].sync});
      check($sformatf("v%0d_pulse", i), {15'h0, pulse_a}, {15'h0, tbl[i].pulse});
      check($sformatf("v%0d_ack", i), {15'h0, ack_a}, {15'h0, tbl[i].ack});
    end
    // hold check: fresh transfer, REQ high for 50 cycles, bus scrambled after capture
    @(negedge clk);
    req_a = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      seen = !ack_a;
    end
    check("hold_ack_low", {15'h0, seen}, 16'h0001);
    @(negedge clk);
    req_a = 1'b1; bus_a = 8'h77;
    pulses = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (pulse_a) pulses++;
      if (k >= 3) bus_a = 8'(k);
    end
    check("hold_pulses", 16'(pulses), 16'd1);
    check("hold_sync", {8'h00, sync_a}, 16'h0077);
    check("hold_ack", {15'h0, ack_a}, 16'h0001);
    // asynchronous reset mid-transfer with REQ still high
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ack", {15'h0, ack_a}, 16'h0000);
    check("arst_sync", {8'h00, sync_a}, 16'h0000);
    check("arst_pulse", {15'h0, pulse_a}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1; bus_a = 8'h5A;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("rel_e%0d_pulse", k), {15'h0, pulse_a}, {15'h0, k == 3});
      check($sformatf("rel_e%0d_sync", k), {8'h00, sync_a}, k == 3 ? 16'h005A : 16'h0000);
    end
    // four-stage, 16-bit instance: capture at edge 5
    @(negedge clk);
    req_b = 1'b1; bus_b = 16'hBEEF;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("w16_e%0d_pulse", k), {15'h0, pulse_b}, {15'h0, k == 5});
      check($sformatf("w16_e%0d_sync", k), sync_b, k >= 5 ? 16'hBEEF : 16'h0000);
    end
    check("w16_ack", {15'h0, ack_b}, 16'h0001);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/data_sync.md
DATA_SYNC -- requirements
Module: data_sync

Interface
REQ-001 Parameter BUS_WIDTH, default 8: width of the data bus carried across the clock domain.
REQ-002 Parameter NUM_STAGES, default 2: number of synchronizer flops on REQ; legal values are 2 or more.
REQ-003 CLK  input  1: destination-domain clock; all state updates on the rising edge.
REQ-004 RST_n  input  1: reset, asynchronous and active-low.
REQ-005 UNSYNC_BUS  input  BUS_WIDTH: source-domain data, held stable by the source from REQ rise until ACK is seen high.
REQ-006 REQ  input  1: source-domain request, asynchronous to CLK, 4-phase level protocol.
REQ-007 SYNC_BUS  output  BUS_WIDTH: registered, captured copy of UNSYNC_BUS.
REQ-008 ENABLE_PULSE  output  1: registered one-cycle strobe marking new SYNC_BUS data.
REQ-009 ACK  output  1: registered level acknowledge returned to the source domain.

Function
REQ-010 REQ passes through a NUM_STAGES flop chain clocked by CLK; the last stage is req_s.
REQ-011 One further flop holds req_d, the value of req_s from the previous cycle.
REQ-012 Rising-edge detect: rise = req_s AND NOT req_d.
REQ-013 FSM has two states: IDLE (ACK=0) and WAIT_LOW (ACK=1).
REQ-014 In IDLE with rise=1, the next edge loads SYNC_BUS from UNSYNC_BUS, sets ENABLE_PULSE=1, sets ACK=1 and enters WAIT_LOW.
REQ-015 ENABLE_PULSE is high for exactly one CLK cycle per capture and is 0 at all other times.
REQ-016 Latency: with REQ stable high before CLK edge 1, SYNC_BUS, ENABLE_PULSE and ACK update at edge NUM_STAGES+1 (edge 3 for the default).
REQ-017 In WAIT_LOW with req_s=0, the next edge clears ACK and enters IDLE; otherwise ACK holds high.
REQ-018 UNSYNC_BUS is sampled on the capture edge only and never passes through the synchronizer chain.
REQ-019 SYNC_BUS holds its value between captures; no capture occurs in WAIT_LOW.
REQ-020 A REQ re-rise after req_s has fallen and the FSM has returned to IDLE is detected normally, giving back-to-back transfers.
REQ-021 A REQ pulse shorter than one CLK period may be missed; the 4-phase protocol prevents this, and the block is not required to detect such pulses.

Reset
REQ-022 RST_n low asynchronously clears all synchronizer flops, req_d, SYNC_BUS, ENABLE_PULSE and ACK to 0, and forces the FSM to IDLE.
REQ-023 Reset asserted mid-transfer drops ACK and ENABLE_PULSE immediately, without waiting for a CLK edge.
REQ-024 If REQ is high when RST_n deasserts, the chain fills from 0 and one capture occurs at edge NUM_STAGES+1 after release.

Verification
REQ-025 Basic transfer, default parameters: UNSYNC_BUS=0xA5, REQ rises before edge 1 -> SYNC_BUS=0xA5, ENABLE_PULSE=1 and ACK=1 at edge 3; ENABLE_PULSE=0 at edge 4.
REQ-026 Release: REQ falls before edge 10 while in WAIT_LOW -> ACK=0 at edge 12 (edge 10 samples, edge 11 gives req_s=0, edge 12 updates ACK), and SYNC_BUS stays 0xA5.
REQ-027 Back-to-back: transfer 0x3C, then 0xC3 with REQ re-raised as soon as ACK=0 -> exactly two ENABLE_PULSE strobes, with SYNC_BUS = 0x3C then 0xC3.
REQ-028 Hold check: REQ held high for 50 cycles -> exactly one ENABLE_PULSE; UNSYNC_BUS changing after capture does not alter SYNC_BUS.
REQ-029 Reset mid-transfer: RST_n pulsed low while ACK=1 -> ACK and SYNC_BUS read 0 before the next CLK edge; with REQ still high, a new capture follows at edge 3 after release.
REQ-030 NUM_STAGES=4, BUS_WIDTH=16: transfer 0xBEEF -> SYNC_BUS=0xBEEF with ENABLE_PULSE at edge 5.
